// File: rtl/snes_video_pkg.sv
// Shared timing defaults, pattern selector and colour type for the synthetic SNES video source.
package snes_video_pkg;

    localparam int DEF_DOT_DIV     = 4;
    localparam int DEF_H_TOTAL     = 341;
    localparam int DEF_H_ACTIVE    = 256;
    localparam int DEF_V_TOTAL     = 262;
    localparam int DEF_V_ACTIVE    = 224;
    localparam int DEF_REFRESH_DOT = 134;
    localparam int DEF_REFRESH_LEN = 40;

    typedef enum logic [1:0] {
        GRADIENT = 2'd0,
        BARS     = 2'd1,
        CHECKER  = 2'd2,
        SOLID    = 2'd3
    } pattern_t;

    typedef logic [14:0] rgb555_t;

endpackage

// File: rtl/snes_video_source_pattern.sv
// Combinational test-pattern generator: maps a dot position and frame number to a 5:5:5 {B,G,R} colour.
module snes_pattern_gen
    import snes_video_pkg::*;
(
    input  logic [7:0] i_hc,
    input  logic [7:0] i_vc,
    input  logic [4:0] i_frame,
    input  pattern_t   i_pattern,
    input  rgb555_t    i_solid,
    output rgb555_t    o_rgb
);

    always_comb begin
        o_rgb = '0;
        case (i_pattern)
            GRADIENT: o_rgb = {i_frame, i_vc[7:3], i_hc[7:3]};
            // Bar index bits 2/1/0 drive B/G/R at full scale.
            BARS:     o_rgb = {{5{i_hc[7]}}, {5{i_hc[6]}}, {5{i_hc[5]}}};
            CHECKER:  o_rgb = (i_hc[3] ^ i_vc[3]) ? 15'h7FFF : 15'h0000;
            SOLID:    o_rgb = i_solid;
            default:  o_rgb = '0;
        endcase
    end

endmodule

// File: rtl/snes_video_source.sv
// Synthetic SNES PPU timing and colour source with frame-sync pause support.
module snes_video_source
    import snes_video_pkg::*;
#(
    parameter int DOT_DIV     = DEF_DOT_DIV,
    parameter int H_TOTAL     = DEF_H_TOTAL,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_TOTAL     = DEF_V_TOTAL,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int REFRESH_DOT = DEF_REFRESH_DOT,
    parameter int REFRESH_LEN = DEF_REFRESH_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pause,
    input  logic [1:0]  pattern,
    input  logic [14:0] solid_color,
    output logic        dotclk,
    output logic        hblank,
    output logic        vblank,
    output logic [8:0]  xs,
    output logic [8:0]  ys,
    output logic [14:0] rgb5,
    output logic        snes_refresh,
    output logic        frame_start
);

    localparam int PH_W = (DOT_DIV > 2) ? $clog2(DOT_DIV) : 1;
    localparam int HC_W = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int VC_W = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
    localparam int RC_W = $clog2(REFRESH_LEN + 1);

    logic [PH_W-1:0] r_ph;
    logic [HC_W-1:0] r_hc;
    logic [VC_W-1:0] r_vc;
    logic            r_field;
    logic [7:0]      r_frame;
    pattern_t        r_pat;
    logic [RC_W-1:0] r_rcnt;
    logic            r_refresh;
    logic            r_dotclk;
    logic            r_hblank;
    logic            r_vblank;
    logic [8:0]      r_xs;
    logic [8:0]      r_ys;
    rgb555_t         r_rgb;
    logic            r_frame_start;

    logic            w_ph_wrap;
    logic            w_hc_wrap;
    logic            w_vc_wrap;
    logic            w_frame_wrap;
    logic [PH_W-1:0] w_ph_n;
    logic [HC_W-1:0] w_hc_n;
    logic [VC_W-1:0] w_vc_n;
    logic            w_field_n;
    logic [7:0]      w_frame_n;
    pattern_t        w_pat_n;
    logic            w_hblank_n;
    logic            w_vblank_n;
    logic            w_dotclk_n;
    logic            w_ref_start;
    rgb555_t         w_pix;

    // Next-state counters; outputs are decoded from these so they track the counters with no lag.
    assign w_ph_wrap    = (r_ph == PH_W'(DOT_DIV - 1));
    assign w_hc_wrap    = (r_hc == HC_W'(H_TOTAL - 1));
    assign w_vc_wrap    = (r_vc == VC_W'(V_TOTAL - 1));
    assign w_frame_wrap = w_ph_wrap & w_hc_wrap & w_vc_wrap;

    assign w_ph_n    = w_ph_wrap ? '0 : r_ph + 1'b1;
    assign w_hc_n    = !w_ph_wrap ? r_hc : (w_hc_wrap ? '0 : r_hc + 1'b1);
    assign w_vc_n    = !(w_ph_wrap && w_hc_wrap) ? r_vc : (w_vc_wrap ? '0 : r_vc + 1'b1);
    assign w_field_n = r_field ^ w_frame_wrap;
    assign w_frame_n = r_frame + {7'd0, w_frame_wrap};
    assign w_pat_n   = w_frame_wrap ? pattern_t'(pattern) : r_pat;

    assign w_hblank_n  = (w_hc_n >= HC_W'(H_ACTIVE));
    assign w_vblank_n  = (w_vc_n >= VC_W'(V_ACTIVE));
    assign w_dotclk_n  = (w_ph_n >= PH_W'(DOT_DIV / 2));
    assign w_ref_start = (w_hc_n == HC_W'(REFRESH_DOT)) && (w_ph_n == '0);

    snes_pattern_gen u_pattern (
        .i_hc      (w_hc_n[7:0]),
        .i_vc      (w_vc_n[7:0]),
        .i_frame   (w_frame_n[4:0]),
        .i_pattern (w_pat_n),
        .i_solid   (solid_color),
        .o_rgb     (w_pix)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph          <= '0;
            r_hc          <= '0;
            r_vc          <= '0;
            r_field       <= 1'b0;
            r_frame       <= '0;
            r_pat         <= GRADIENT;
            r_rcnt        <= '0;
            r_refresh     <= 1'b0;
            r_dotclk      <= 1'b0;
            r_hblank      <= 1'b0;
            r_vblank      <= 1'b0;
            r_xs          <= '0;
            r_ys          <= '0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_wrap && !pause;
            if (!pause) begin
                r_ph     <= w_ph_n;
                r_hc     <= w_hc_n;
                r_vc     <= w_vc_n;
                r_field  <= w_field_n;
                r_frame  <= w_frame_n;
                r_pat    <= w_pat_n;
                r_dotclk <= w_dotclk_n;
                r_hblank <= w_hblank_n;
                r_vblank <= w_vblank_n;
                r_xs     <= {w_hc_n[7:0], w_dotclk_n};
                r_ys     <= {w_field_n, w_vc_n[7:0]};
                // Colour is captured half a dot early so it is settled at the dotclk rising edge.
                if (w_ph_n == PH_W'(DOT_DIV / 2 - 1))
                    r_rgb <= (w_hblank_n || w_vblank_n) ? '0 : w_pix;
                if (w_ref_start) begin
                    r_refresh <= 1'b1;
                    r_rcnt    <= RC_W'(REFRESH_LEN - 1);
                end else if (r_refresh) begin
                    if (r_rcnt == '0)
                        r_refresh <= 1'b0;
                    else
                        r_rcnt <= r_rcnt - 1'b1;
                end
            end
        end
    end

    assign dotclk       = r_dotclk;
    assign hblank       = r_hblank;
    assign vblank       = r_vblank;
    assign xs           = r_xs;
    assign ys           = r_ys;
    assign rgb5         = r_rgb;
    assign snes_refresh = r_refresh;
    assign frame_start  = r_frame_start;

endmodule
